// File: rtl/fp_addsub_hs_if.sv
// fp_addsub_hs_if: operand/result handshake bundle for the pipelined fp adder.
//   in_valid/in_ready   : operation handshake (a, b, op_sub, round_mode, tag_in)
//   out_valid/out_ready : result handshake (result, flags {NV,OF,UF,NX}, tag_out)
// master = operand scheduler + writeback side, slave = the adder.
interface fp_addsub_hs_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_sub;
   logic [2:0]       round_mode;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic [TAG_W-1:0] tag_out;

   modport master (
      output in_valid, a, b, op_sub, round_mode, tag_in, out_ready,
      input  in_ready, out_valid, result, flags, tag_out
   );

   modport slave (
      input  in_valid, a, b, op_sub, round_mode, tag_in, out_ready,
      output in_ready, out_valid, result, flags, tag_out
   );
endinterface

// File: rtl/fp_addsub_hs.sv
// fp_addsub_hs: 4-stage IEEE 754 add/sub with runtime op and rounding mode,
// valid/ready backpressure, denormal results, exception flags and a user tag.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   io       : fp_addsub_hs_if.slave (operands in, result/flags/tag out)
// Rounding modes: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM. flags = {NV, OF, UF, NX}.
module fp_addsub_hs #(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 4,
   parameter int GUARD_W = 3
) (
   input  logic          clk,
   input  logic          rst,
   fp_addsub_hs_if.slave io
);
   localparam int EXP_W  = (WIDTH == 16) ? 5 : (WIDTH == 32) ? 8 : 11;
   localparam int MANT_W = WIDTH - EXP_W - 1;
   localparam int W      = MANT_W + 1 + GUARD_W;   // significand + guard bits
   localparam logic [2:0] RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [WIDTH-2:0] INF_MAG  = {EXP_ONES, {MANT_W{1'b0}}};
   localparam logic [WIDTH-2:0] MAX_MAG  = {{(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
   localparam logic [WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

   if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
      $error("fp_addsub_hs: WIDTH must be 16, 32 or 64");
   end
   if (TAG_W < 1 || GUARD_W < 3) begin : g_bad_param
      $error("fp_addsub_hs: TAG_W >= 1 and GUARD_W >= 3 required");
   end

   // Control carried unchanged down the pipe; specials ride along and
   // replace the arithmetic result at the end.
   typedef struct packed {
      logic             sign;
      logic             eff_sub;
      logic [2:0]       rm;
      logic [TAG_W-1:0] tag;
      logic             spec;
      logic             spec_nv;
      logic [WIDTH-1:0] spec_res;
   } ctl_t;

   logic [4:1] vld_pipe;
   logic       en;
   assign en           = io.out_ready || !vld_pipe[4];
   assign io.in_ready  = en;
   assign io.out_valid = vld_pipe[4];

   // ---- stage 1: unpack, compare, align ----
   ctl_t             c1_n, c1, c2, c3;
   logic             sa, sb, a_big, a_ones, b_ones, a_mz, b_mz, a_nan, b_nan, stk;
   logic [WIDTH-2:0] mag_l, mag_s;
   logic [EXP_W-1:0] e_l, e_s, d, e1, e2, ef_n, ef3;
   logic [W-1:0]     big_n, sml_x, sml_n, big1, sml1, n3_n;
   logic [W:0]       sum_n, sum2;
   logic [W-2:0]     n3;
   logic             z3;

   always_comb begin
      sa    = io.a[WIDTH-1];
      sb    = io.b[WIDTH-1] ^ io.op_sub;
      a_big = io.a[WIDTH-2:0] >= io.b[WIDTH-2:0];
      mag_l = a_big ? io.a[WIDTH-2:0] : io.b[WIDTH-2:0];
      mag_s = a_big ? io.b[WIDTH-2:0] : io.a[WIDTH-2:0];
      // denormals: exponent 1, implicit bit 0
      e_l   = mag_l[WIDTH-2:MANT_W] | EXP_W'(~|mag_l[WIDTH-2:MANT_W]);
      e_s   = mag_s[WIDTH-2:MANT_W] | EXP_W'(~|mag_s[WIDTH-2:MANT_W]);
      d     = e_l - e_s;
      big_n = {|mag_l[WIDTH-2:MANT_W], mag_l[MANT_W-1:0], {GUARD_W{1'b0}}};
      sml_x = {|mag_s[WIDTH-2:MANT_W], mag_s[MANT_W-1:0], {GUARD_W{1'b0}}};
      if (32'(d) >= W) begin
         sml_n = '0;
         stk   = |sml_x;
      end else begin
         sml_n = sml_x >> d;
         stk   = |(sml_x & ((W'(1) << d) - W'(1)));
      end
      sml_n[0] = sml_n[0] | stk;   // lowest guard bit collects sticky

      a_ones = &io.a[WIDTH-2:MANT_W];
      b_ones = &io.b[WIDTH-2:MANT_W];
      a_mz   = ~|io.a[MANT_W-1:0];
      b_mz   = ~|io.b[MANT_W-1:0];
      a_nan  = a_ones && !a_mz;
      b_nan  = b_ones && !b_mz;

      c1_n          = '0;
      c1_n.sign     = a_big ? sa : sb;
      c1_n.eff_sub  = sa ^ sb;
      c1_n.rm       = io.round_mode;
      c1_n.tag      = io.tag_in;
      c1_n.spec     = a_ones || b_ones;
      c1_n.spec_res = QNAN;
      if (a_nan || b_nan)
         c1_n.spec_nv = (a_nan && !io.a[MANT_W-1]) || (b_nan && !io.b[MANT_W-1]);
      else if (a_ones && b_ones && (sa != sb))
         c1_n.spec_nv = 1'b1;
      else if (a_ones)
         c1_n.spec_res = {sa, INF_MAG};
      else
         c1_n.spec_res = {sb, INF_MAG};
   end

   // ---- stage 2: significand add/sub with carry ----
   always_comb begin
      sum_n = c1.eff_sub ? ({1'b0, big1} - {1'b0, sml1}) : ({1'b0, big1} + {1'b0, sml1});
   end

   // ---- stage 3: normalise ----
   function automatic int lzc(input logic [W-1:0] v);
      lzc = W;
      for (int i = 0; i < W; i++)
         if (v[i]) lzc = W - 1 - i;
   endfunction

   int lz, lim, sh;
   logic [EXP_W-1:0] e3_n;
   always_comb begin
      lz  = lzc(sum2[W-1:0]);
      lim = int'(e2) - 1;                 // never normalise below exponent 1
      sh  = (lz < lim) ? lz : lim;
      if (sum2[W]) begin
         n3_n = {sum2[W:2], sum2[1] | sum2[0]};
         e3_n = e2 + EXP_W'(1);
      end else begin
         n3_n = sum2[W-1:0] << sh;
         e3_n = e2 - EXP_W'(sh);
      end
      // no leading one after a limited shift -> denormal encoding
      ef_n = n3_n[W-1] ? e3_n : '0;
   end

   // ---- stage 4: round and pack ----
   logic             g, r, inx, inc, ovf, tiny, sgn, to_inf;
   logic [WIDTH-1:0] rnd, res_n, result_q;
   logic [3:0]       flg_n, flags_q;
   logic [TAG_W-1:0] tag_q;

   always_comb begin
      g   = n3[GUARD_W-1];
      r   = |n3[GUARD_W-2:0];
      inx = g || r;
      sgn = z3 ? (c3.eff_sub ? (c3.rm == RDN) : c3.sign) : c3.sign;
      case (c3.rm)
         RTZ:     inc = 1'b0;
         RDN:     inc = sgn && inx;
         RUP:     inc = !sgn && inx;
         RMM:     inc = g;
         default: inc = g && (r || n3[GUARD_W]);
      endcase
      // exponent and mantissa packed together so mantissa carry bumps the
      // exponent (denormal -> 2^emin, max -> overflow) for free
      rnd  = {1'b0, ef3, n3[W-2:GUARD_W]} + WIDTH'(inc);
      ovf  = rnd[WIDTH-1] || (&rnd[WIDTH-2:MANT_W]);
      tiny = ~|rnd[WIDTH-2:MANT_W];
      case (c3.rm)
         RTZ:     to_inf = 1'b0;
         RDN:     to_inf = sgn;
         RUP:     to_inf = !sgn;
         default: to_inf = 1'b1;
      endcase
      if (c3.spec) begin
         res_n = c3.spec_res;
         flg_n = {c3.spec_nv, 3'b000};
      end else if (ovf) begin
         res_n = {sgn, to_inf ? INF_MAG : MAX_MAG};
         flg_n = 4'b0101;
      end else begin
         res_n = {sgn, rnd[WIDTH-2:0]};
         flg_n = {2'b00, tiny && inx, inx};
      end
   end

   // ---- registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         result_q <= '0;
         flags_q  <= '0;
         tag_q    <= '0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[3:1], io.in_valid};
         result_q <= res_n;
         flags_q  <= flg_n;
         tag_q    <= c3.tag;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         c1   <= c1_n;
         e1   <= e_l;
         big1 <= big_n;
         sml1 <= sml_n;
         c2   <= c1;
         e2   <= e1;
         sum2 <= sum_n;
         c3   <= c2;
         ef3  <= ef_n;
         n3   <= n3_n[W-2:0];
         z3   <= ~|sum2;
      end
   end

   assign io.result  = result_q;
   assign io.flags   = flags_q;
   assign io.tag_out = tag_q;
endmodule

// File: tb/tb_fp_addsub_hs.sv
// tb_fp_addsub_hs: fp16 scoreboard bench for fp_addsub_hs. Expected results
// are queued when an op is accepted and compared when the DUT emits one.
module tb_fp_addsub_hs;
   localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

   logic clk, rst;
   int   n_chk = 0, n_bad = 0;

   fp_addsub_hs_if #(.WIDTH(16), .TAG_W(4)) bus ();
   fp_addsub_hs #(.WIDTH(16), .TAG_W(4), .GUARD_W(3)) dut (.clk(clk), .rst(rst), .io(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flg;
      logic [3:0]  tg;
   } exp_t;
   exp_t sb_q[$];

   logic        stalled = 1'b0;
   logic [15:0] held_res;
   logic [3:0]  held_flg, held_tg;
   logic [15:0] ival [0:16];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // output monitor: scoreboard compare plus stall stability
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) stalled = 1'b0;
      else begin
         if (stalled) begin
            chk("hold_vld", 64'(bus.out_valid), 64'd1);
            chk("hold_res", 64'(bus.result), 64'(held_res));
            chk("hold_flg", 64'(bus.flags), 64'(held_flg));
            chk("hold_tag", 64'(bus.tag_out), 64'(held_tg));
         end
         if (bus.out_valid && !bus.out_ready) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            stalled  = 1'b1;
            held_res = bus.result;
            held_flg = bus.flags;
            held_tg  = bus.tag_out;
         end else stalled = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) chk("spurious_out", 64'(bus.out_valid), 64'd0);
            else begin
               e = sb_q.pop_front();
               chk("result", 64'(bus.result), 64'(e.res));
               chk("flags", 64'(bus.flags), 64'(e.flg));
               chk("tag", 64'(bus.tag_out), 64'(e.tg));
            end
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [2:0] rm, input logic [3:0] tg,
                       input logic [15:0] er, input logic [3:0] ef);
      int n;
      exp_t e;
      n = 0;
      bus.in_valid   = 1'b1;
      bus.a          = a;
      bus.b          = b;
      bus.op_sub     = sub;
      bus.round_mode = rm;
      bus.tag_in     = tg;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      else begin
         e.res = er;
         e.flg = ef;
         e.tg  = tg;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      ival = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
               16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80,
               16'h4B00, 16'h4B80, 16'h4C00};
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op_sub = 1'b0;
      bus.round_mode = RNE; bus.tag_in = '0; bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_flags", 64'(bus.flags), 64'd0);
      chk("rst_tag", 64'(bus.tag_out), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // latency of a lone op: accept edge plus three more
      send(16'h3C00, 16'h3C00, 1'b0, RNE, 4'd5, 16'h4000, 4'h0);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'd4);
      drain();

      // rounding ties
      send(16'h3C00, 16'h1000, 1'b0, RNE, 4'd1, 16'h3C00, 4'h1);
      send(16'h3C00, 16'h1000, 1'b0, RUP, 4'd2, 16'h3C01, 4'h1);
      send(16'h3C00, 16'h1000, 1'b0, RTZ, 4'd3, 16'h3C00, 4'h1);
      send(16'h3C00, 16'h1000, 1'b0, RMM, 4'd4, 16'h3C01, 4'h1);
      send(16'hBC00, 16'h9000, 1'b0, RDN, 4'd5, 16'hBC01, 4'h1);
      // overflow per mode
      send(16'h7BFF, 16'h7BFF, 1'b0, RNE, 4'd6, 16'h7C00, 4'h5);
      send(16'h7BFF, 16'h7BFF, 1'b0, RTZ, 4'd7, 16'h7BFF, 4'h5);
      send(16'hFBFF, 16'hFBFF, 1'b0, RUP, 4'd8, 16'hFBFF, 4'h5);
      send(16'h7BFF, 16'h7BFF, 1'b0, RDN, 4'd9, 16'h7BFF, 4'h5);
      send(16'h7BFF, 16'h7BFF, 1'b0, RUP, 4'd10, 16'h7C00, 4'h5);
      // denormals and zeros
      send(16'h0400, 16'h0001, 1'b1, RNE, 4'd11, 16'h03FF, 4'h0);
      send(16'h0001, 16'h0001, 1'b0, RNE, 4'd12, 16'h0002, 4'h0);
      send(16'h03FF, 16'h0001, 1'b0, RNE, 4'd13, 16'h0400, 4'h0);
      send(16'h3C00, 16'h3C00, 1'b1, RDN, 4'd14, 16'h8000, 4'h0);
      send(16'h3C00, 16'h3C00, 1'b1, RNE, 4'd15, 16'h0000, 4'h0);
      send(16'h8000, 16'h8000, 1'b0, RNE, 4'd0, 16'h8000, 4'h0);
      send(16'h0000, 16'h8000, 1'b0, RNE, 4'd1, 16'h0000, 4'h0);
      send(16'h0000, 16'h8000, 1'b0, RDN, 4'd2, 16'h8000, 4'h0);
      // specials
      send(16'h7C00, 16'hFC00, 1'b0, RNE, 4'd3, 16'h7E00, 4'h8);
      send(16'h7D00, 16'h3C00, 1'b0, RNE, 4'd4, 16'h7E00, 4'h8);
      send(16'h7E00, 16'h3C00, 1'b0, RNE, 4'd5, 16'h7E00, 4'h0);
      send(16'h7C00, 16'h3C00, 1'b0, RNE, 4'd6, 16'h7C00, 4'h0);
      send(16'h3C00, 16'h7C00, 1'b1, RNE, 4'd7, 16'hFC00, 4'h0);
      drain();

      // back-to-back with a 5-cycle output stall: k + k = 2k
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(ival[i+1], ival[i+1], 1'b0, RNE, 4'(i), ival[2*i+2], 4'h0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // reset with three ops in flight: nothing may emerge afterwards
      send(16'h3C00, 16'h3C00, 1'b0, RNE, 4'd1, 16'h4000, 4'h0);
      send(16'h4000, 16'h4000, 1'b0, RNE, 4'd2, 16'h4400, 4'h0);
      send(16'h4200, 16'h4200, 1'b0, RNE, 4'd3, 16'h4600, 4'h0);
      rst = 1'b1;
      sb_q.delete();
      @(posedge clk);
      #1;
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_result", 64'(bus.result), 64'd0);
      chk("flush_tag", 64'(bus.tag_out), 64'd0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("post_flush_valid", 64'(bus.out_valid), 64'd0);

      // pipe still works after the flush
      send(16'h4400, 16'h3C00, 1'b1, RNE, 4'd9, 16'h4200, 4'h0);
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
